// File: rtl/opl_host_fifo_if.sv
// Host write front end for NUM_CHIPS OPL3 instances: strobe decode, per-chip/bank index latches,
// write FIFO with minimum pop spacing, and status readback. Optional busy bit: OPL_HOST_BUSY_STATUS_EN.
module opl_host_fifo_if #(
  parameter int NUM_CHIPS  = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_WR_GAP = 4,
  parameter int DATA_WIDTH = 8,
  localparam int CW = ($clog2(NUM_CHIPS) > 1) ? $clog2(NUM_CHIPS) : 1,
  localparam int AW = CW + 2
) (
  input  logic                            clk,
  input  logic                            ic_n,
  input  logic                            cs_n,
  input  logic                            rd_n,
  input  logic                            wr_n,
  input  logic [AW-1:0]                   address,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [DATA_WIDTH-1:0]           dout,
  input  logic [NUM_CHIPS*DATA_WIDTH-1:0] status_in,
  output logic                            reg_wr_valid,
  input  logic                            reg_wr_ready,
  output logic [CW-1:0]                   reg_wr_chip,
  output logic                            reg_wr_bank,
  output logic [DATA_WIDTH-1:0]           reg_wr_address,
  output logic [DATA_WIDTH-1:0]           reg_wr_data,
  output logic                            fifo_overflow,
  input  logic                            ovf_clr
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(MIN_WR_GAP - 1);
  localparam logic [PW:0]   DEPTH_C    = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW:0]   NC_C       = (CW+1)'(NUM_CHIPS);

  typedef struct packed {
    logic [CW-1:0] chip;
    logic          bank;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } wr_ent_t;

  logic          wr_idle_q, rd_idle_q;
  logic          wr_act, rd_act, wr_stb, rd_stb;
  logic [CW-1:0] a_chip, chip_sel;
  logic          a_bank, a_port, chip_ok;

  logic [NUM_CHIPS-1:0][1:0][DW-1:0] idx_q;
  wr_ent_t       mem_q [FIFO_DEPTH];
  wr_ent_t       head, push_ent;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] dout_q, dout_d, rd_data;
  logic          full, empty, push_req, push, pop, drop, busy;

  // Strobes fire only on the first cycle of an assertion; a write masks a concurrent read.
  assign wr_act = !cs_n && !wr_n;
  assign rd_act = !cs_n && !rd_n;
  assign wr_stb = wr_act && wr_idle_q;
  assign rd_stb = rd_act && rd_idle_q && !wr_act;

  assign a_chip   = address[AW-1:2];
  assign a_bank   = address[1];
  assign a_port   = address[0];
  assign chip_ok  = {1'b0, a_chip} < NC_C;
  assign chip_sel = chip_ok ? a_chip : '0;

  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign head     = mem_q[rptr_q];
  assign push_ent = '{chip: a_chip, bank: a_bank, addr: idx_q[chip_sel][a_bank], data: din};

  assign reg_wr_valid   = !empty && (gap_q == '0);
  assign pop            = reg_wr_valid && reg_wr_ready;
  assign push_req       = wr_stb && chip_ok && a_port;
  assign push           = push_req && (!full || pop);
  assign drop           = push_req && full && !pop;

  assign reg_wr_chip    = head.chip;
  assign reg_wr_bank    = head.bank;
  assign reg_wr_address = head.addr;
  assign reg_wr_data    = head.data;
  assign fifo_overflow  = ovf_q;
  assign dout           = dout_q;

`ifdef OPL_HOST_BUSY_STATUS_EN
  logic [NUM_CHIPS-1:0] busy_vec;
  for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_pend
    logic [PW:0] pend_q;
    logic        inc, dec;
    assign inc = push && (push_ent.chip == CW'(c));
    assign dec = pop && (head.chip == CW'(c));
    always_ff @(posedge clk) begin
      if (!ic_n)             pend_q <= '0;
      else if (inc && !dec)  pend_q <= pend_q + 1'b1;
      else if (dec && !inc)  pend_q <= pend_q - 1'b1;
    end
    assign busy_vec[c] = (pend_q != '0);
  end
  assign busy = busy_vec[chip_sel];
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    rd_data = '1;
    if (!a_port && chip_ok)
      rd_data = status_in[chip_sel*DW +: DW] | {{(DW-1){1'b0}}, busy};
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    gap_d = gap_q;
    if (pop)                gap_d = GAP_RELOAD;
    else if (gap_q != '0)   gap_d = gap_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)               ovf_d = 1'b1;
    else if (ovf_clr)       ovf_d = 1'b0;
    dout_d = rd_stb ? rd_data : dout_q;
  end

  always_ff @(posedge clk) begin
    if (!ic_n) begin
      wr_idle_q <= 1'b1;
      rd_idle_q <= 1'b1;
      idx_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      ovf_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_idle_q <= !wr_act;
      rd_idle_q <= !rd_act;
      if (wr_stb && chip_ok && !a_port) idx_q[chip_sel][a_bank] <= din;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
      ovf_q  <= ovf_d;
      dout_q <= dout_d;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_ent;
  end

endmodule

// File: tb/tb_opl_host_fifo_if.sv
// Scoreboard bench for opl_host_fifo_if: stimulus queues expected core writes, a negedge monitor checks pops.
module tb_opl_host_fifo_if;
  localparam int NC = 2, FD = 16, GAP = 4, DW = 8, CW = 1, AW = 3;

  logic              clk = 1'b0;
  logic              ic_n, cs_n, rd_n, wr_n;
  logic [AW-1:0]     address;
  logic [DW-1:0]     din, dout;
  logic [NC*DW-1:0]  status_in;
  logic              reg_wr_valid, reg_wr_ready;
  logic [CW-1:0]     reg_wr_chip;
  logic              reg_wr_bank;
  logic [DW-1:0]     reg_wr_address, reg_wr_data;
  logic              fifo_overflow, ovf_clr;

  opl_host_fifo_if #(.NUM_CHIPS(NC), .FIFO_DEPTH(FD), .MIN_WR_GAP(GAP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .ic_n(ic_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .address(address),
    .din(din), .dout(dout), .status_in(status_in), .reg_wr_valid(reg_wr_valid),
    .reg_wr_ready(reg_wr_ready), .reg_wr_chip(reg_wr_chip), .reg_wr_bank(reg_wr_bank),
    .reg_wr_address(reg_wr_address), .reg_wr_data(reg_wr_data),
    .fifo_overflow(fifo_overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

`ifdef OPL_HOST_BUSY_STATUS_EN
  localparam logic [7:0] ST1_BUSY = 8'hE1;
`else
  localparam logic [7:0] ST1_BUSY = 8'hE0;
`endif

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int last_pop = -1000;
  logic [CW+2*DW:0] exp_q[$];
  logic [CW+2*DW:0] mon_got;
  int pop_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready here.
  always @(negedge clk) begin
    if (ic_n === 1'b1 && reg_wr_valid === 1'b1 && reg_wr_ready === 1'b1) begin
      mon_got = {reg_wr_chip, reg_wr_bank, reg_wr_address, reg_wr_data};
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_pop: got %0h expected none", mon_got);
      end else begin
        chk("pop_entry", 32'(mon_got), 32'(exp_q.pop_front()));
      end
      chk("pop_min_gap", 32'((cyc - last_pop) >= GAP), 32'd1);
      last_pop = cyc;
      pop_log.push_back(cyc);
    end
  end

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; address = a; din = d;
    repeat (hold) @(posedge clk);
    #1; cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic host_rd(input logic [AW-1:0] a);
    @(posedge clk); #1;
    cs_n = 1'b0; rd_n = 1'b0; address = a;
    @(posedge clk); #1;
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wr_data(input logic [AW-1:0] a, input logic [DW-1:0] idx,
                         input logic [DW-1:0] d, input int hold);
    logic [AW-1:0] av;
    av = a;
    exp_q.push_back({av[AW-1:2], av[1], idx, d});
    host_wr(a, d, hold);
  endtask

  task automatic wait_drain(input int max);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || reg_wr_valid) && i < max) begin
      @(posedge clk); #1; i++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    ic_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; address = '0; din = '0;
    status_in = {8'hE0, 8'h11}; reg_wr_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(reg_wr_valid), 32'd0);
    chk("rst_ovf", 32'(fifo_overflow), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    ic_n = 1'b1;

    // 1: index then data write, single-cycle latency to valid
    reg_wr_ready = 1'b1;
    host_wr(3'b000, 8'h20, 1);
    wr_data(3'b001, 8'h20, 8'h81, 1);
    chk("t1_valid_lat", 32'(reg_wr_valid), 32'd1);
    @(posedge clk); #1;
    chk("t1_valid_low", 32'(reg_wr_valid), 32'd0);
    wait_drain(20);
    repeat (GAP) @(posedge clk);

    // 2: five writes to chip1 bank1, pops exactly GAP apart
    host_wr(3'b110, 8'h5A, 1);
    pop_log.delete();
    for (int i = 0; i < 5; i++) wr_data(3'b111, 8'h5A, 8'(8'h10 + i), 1);
    wait_drain(100);
    chk("t2_pop_count", 32'(pop_log.size()), 32'd5);
    for (int i = 1; i < 5 && i < pop_log.size(); i++)
      chk("t2_pop_spacing", 32'(pop_log[i] - pop_log[i-1]), 32'(GAP));

    // 3: overflow on the 17th write, clear, drain first 16 in order
    reg_wr_ready = 1'b0;
    host_wr(3'b010, 8'h40, 1);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) wr_data(3'b011, 8'h40, 8'(8'h30 + i), 1);
      else        host_wr(3'b011, 8'(8'h30 + i), 1);
      if (i == 15) chk("t3_ovf_at_full", 32'(fifo_overflow), 32'd0);
    end
    chk("t3_ovf_set", 32'(fifo_overflow), 32'd1);
    chk("t3_valid_held", 32'(reg_wr_valid), 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(fifo_overflow), 32'd0);
    reg_wr_ready = 1'b1;
    wait_drain(200);

    // 4: long strobe pushes once; status reads
    reg_wr_ready = 1'b0;
    repeat (GAP) @(posedge clk);
    wr_data(3'b101, 8'h00, 8'h77, 10);
    chk("t4_valid", 32'(reg_wr_valid), 32'd1);
    host_rd(3'b100);
    chk("t4_status1_pending", 32'(dout), 32'(ST1_BUSY));
    host_rd(3'b000);
    chk("t4_status0", 32'(dout), 32'h11);
    host_rd(3'b101);
    chk("t4_data_port_rd", 32'(dout), 32'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_dout_hold", 32'(dout), 32'hFF);
    reg_wr_ready = 1'b1;
    wait_drain(50);
    host_rd(3'b100);
    chk("t4_status1_idle", 32'(dout), 32'hE0);

    // 5: reset mid-operation discards queue and index latches
    reg_wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr_data(3'b001, 8'h20, 8'(8'hA0 + i), 1);
    chk("t5_valid_pre", 32'(reg_wr_valid), 32'd1);
    @(posedge clk); #1;
    ic_n = 1'b0;
    @(posedge clk); #1;
    ic_n = 1'b1;
    exp_q.delete();
    last_pop = -1000;
    chk("t5_rst_valid", 32'(reg_wr_valid), 32'd0);
    chk("t5_rst_ovf", 32'(fifo_overflow), 32'd0);
    chk("t5_rst_dout", 32'(dout), 32'd0);
    reg_wr_ready = 1'b1;
    pop_log.delete();
    wr_data(3'b001, 8'h00, 8'h99, 1);
    wait_drain(30);
    repeat (GAP + 2) @(posedge clk);
    chk("t5_single_pop", 32'(pop_log.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/opl_host_fifo_if.md
Name: opl_host_fifo_if

Overview:
Multi-chip host write front end for the OPL synthesis core.
- Decodes host bus cycles for NUM_CHIPS OPL3 instances, each with two register banks.
- Latches a per-chip/per-bank register index.
- Queues full register writes in a FIFO and drains them to the core with a valid/ready handshake, with a guaranteed minimum gap between writes (models OPL write-recovery time).
- Returns per-chip status on host reads.
- Sits between the host bus and the channel/timer logic of every OPL instance.

Parameters:
- NUM_CHIPS, 2, number of OPL instances addressed; 1..4.
- FIFO_DEPTH, 16, queued writes; power of two, >=2.
- MIN_WR_GAP, 4, minimum clk cycles between successive pops; >=1.
- DATA_WIDTH, 8, register data and index width.
- CW (localparam), max(1,$clog2(NUM_CHIPS)), chip field width.
- AW (localparam), CW+2, host address width.

Ports:
- clk  in  1  block clock; all logic on rising edge.
- ic_n  in  1  synchronous active-low reset.
- cs_n  in  1  host chip select, active-low.
- rd_n  in  1  host read strobe, active-low.
- wr_n  in  1  host write strobe, active-low.
- address  in  AW  {chip, bank, port}; port 0=index, 1=data.
- din  in  DATA_WIDTH  host write data.
- dout  out  DATA_WIDTH  host read data, registered.
- status_in  in  NUM_CHIPS*DATA_WIDTH  status byte per chip from timers.
- reg_wr_valid  out  1  queued write available.
- reg_wr_ready  in  1  core accepts the write.
- reg_wr_chip  out  CW  target chip.
- reg_wr_bank  out  1  target bank.
- reg_wr_address  out  DATA_WIDTH  register index.
- reg_wr_data  out  DATA_WIDTH  register data.
- fifo_overflow  out  1  sticky; a data write was dropped.
- ovf_clr  in  1  clears fifo_overflow.

Behaviour:
- Reset (ic_n low at an edge):
  - dout=0, reg_wr_valid=0, fifo_overflow=0.
  - FIFO emptied, all index latches=0, gap counter=0, strobe history set to inactive.
  - Queued entries are discarded when reset occurs mid-operation.
- Strobes:
  - wr_strobe = !cs_n & !wr_n in the current cycle, and (cs_n|wr_n) in the previous cycle.
  - rd_strobe is defined the same way with rd_n.
  - One action per host assertion, however long the assertion lasts.
  - If rd and wr are both asserted, the write wins and the read is ignored.
- Chip field >= NUM_CHIPS: writes are ignored; reads return all-ones.
- Index write (port 0): index[chip][bank] <= din at the strobe edge.
- Data write (port 1):
  - Pushes {chip, bank, index[chip][bank], din}.
  - An index write in any earlier cycle is used.
  - The index latch is unchanged by a data write.
- Full FIFO:
  - Push with no pop in the same cycle: entry dropped, fifo_overflow <= 1.
  - Push with a simultaneous pop: push accepted, occupancy unchanged.
- Empty FIFO: no pop.
- Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Output:
  - Head entry is driven combinationally from FIFO storage.
  - reg_wr_valid = !empty & (gap==0).
  - Pop occurs on valid & ready.
  - On pop, gap <= MIN_WR_GAP-1; gap decrements to 0 while nonzero.
  - Pops are therefore >= MIN_WR_GAP cycles apart; MIN_WR_GAP=1 allows back-to-back pops.
  - Latency: data strobe at edge N into an empty FIFO with gap 0 gives valid high after edge N (1 cycle). Head fields are stable while valid & !ready.
- Reads:
  - Port 0: dout <= status_in[chip].
  - Port 1: dout <= all-ones.
  - dout is registered 1 cycle after the strobe and holds until the next read strobe.
- ovf_clr:
  - fifo_overflow <= 0.
  - If a drop happens in the same cycle, set wins.

Optional Feature:
OPL_HOST_BUSY_STATUS_EN
- Defined:
  - Per-chip pending counters (width log2(FIFO_DEPTH)+1) increment on push and decrement on pop for that chip; simultaneous push and pop leave the counter unchanged.
  - Status read returns status_in[chip] with bit 0 forced to 1 while pending[chip] != 0.
- Undefined:
  - No counters are built; status is passed through unmodified.

Test Plan:
- Index write addr=0b000 din=0x20, then data write addr=0b001 din=0x81, ready=1 -> valid 1 cycle after data strobe with chip0 bank0 addr 0x20 data 0x81, then low.
- 5 data writes to chip1 bank1 (addr=0b111) with ready=1, MIN_WR_GAP=4 -> exactly 5 pops, consecutive pops exactly 4 cycles apart, order preserved.
- Hold ready=0, issue 17 data writes, FIFO_DEPTH=16 -> 16 entries queued, fifo_overflow=1; pulse ovf_clr -> 0; drain yields the first 16 in order.
- Hold wr_n low for 10 cycles on a data write -> one entry pushed; read addr=0b100 with status_in[1]=0xE0 -> dout=0xE0 one cycle after strobe (0xE1 with OPL_HOST_BUSY_STATUS_EN while chip1 entries are pending).
- Fill 8 entries, assert ic_n low for one edge -> valid=0, fifo_overflow=0, dout=0; following data write is the only entry popped, using index 0x00.
